// File: rtl/apb_ram_ws_if.sv
// APB4 bus bundle for the apb_ram_ws scratch RAM.
// The slave modport is used by the RAM and the master modport by whatever drives it.
interface apb_ram_ws_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_psel;
  logic                  i_penable;
  logic                  i_pwrite;
  logic [ADDR_W-1:0]     i_paddr;
  logic [DATA_W-1:0]     i_pwdata;
  logic [DATA_W/8-1:0]   i_pstrb;
  logic [DATA_W-1:0]     o_prdata;
  logic                  o_pready;
  logic                  o_pslverr;

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
    output o_prdata, o_pready, o_pslverr
  );

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
    input  o_prdata, o_pready, o_pslverr
  );
endinterface

// File: rtl/apb_ram_ws.sv
// Parametrised APB4 slave RAM with byte strobes, programmable wait states,
// an optional read-only upper region and a post-reset scrub that zeroes the array.
module apb_ram_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = DEPTH
) (
  input  logic         i_pclk,
  input  logic         i_presetn,
  apb_ram_ws_if.slave  bus
);

  localparam int LANES = DATA_W / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] LSB_MASK   = ADDR_W'((1 << LSB) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] RO_BASE_A  = ADDR_W'(RO_BASE);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_STATES);

  localparam logic [1:0] ST_SCRUB = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  scrub_ptr;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q;
  logic              pslverr_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              access;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              ro_violation;
  logic              req_err;
  logic              resp_enter;
  logic              commit;
  logic              scrub_we;

  // Decode the current request and decide whether this edge enters the response phase.
  always_comb begin
    access       = bus.i_psel && bus.i_penable;
    word_addr    = bus.i_paddr >> LSB;
    word_idx     = bus.i_paddr[LSB +: IDX_W];
    misaligned   = (bus.i_paddr & LSB_MASK) != '0;
    out_of_range = word_addr >= DEPTH_A;
    ro_violation = bus.i_pwrite && (word_addr >= RO_BASE_A);
    req_err      = misaligned || out_of_range || ro_violation;
    resp_enter   = 1'b0;
    if (state == ST_IDLE && access && WAIT_STATES == 0) begin
      resp_enter = 1'b1;
    end
    if (state == ST_WAIT && access && wait_cnt == 4'd1) begin
      resp_enter = 1'b1;
    end
    commit   = resp_enter && bus.i_pwrite && !req_err;
    scrub_we = state == ST_SCRUB;
  end

  // Sequencer plus registered response; outputs default to zero so they only show in RESP.
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      state     <= ST_SCRUB;
      scrub_ptr <= '0;
      wait_cnt  <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      if (resp_enter) begin
        pready_q  <= 1'b1;
        pslverr_q <= req_err;
        prdata_q  <= (req_err || bus.i_pwrite) ? '0 : mem[word_idx];
      end
      case (state)
        ST_SCRUB: begin
          scrub_ptr <= scrub_ptr + 1'b1;
          if (scrub_ptr == LAST_IDX) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (access) begin
            wait_cnt <= WAIT_INIT;
            state    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!access) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd1) begin
            wait_cnt <= '0;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage has no reset: the scrub pass clears it, otherwise committed writes land per lane.
  always_ff @(posedge i_pclk) begin
    if (scrub_we) begin
      mem[scrub_ptr] <= '0;
    end else if (commit) begin
      for (int b = 0; b < LANES; b++) begin
        if (bus.i_pstrb[b]) begin
          mem[word_idx][b*8 +: 8] <= bus.i_pwdata[b*8 +: 8];
        end
      end
    end
  end

  assign bus.o_prdata  = prdata_q;
  assign bus.o_pready  = pready_q;
  assign bus.o_pslverr = pslverr_q;

endmodule

// File: doc/apb_ram_ws.md
Name: apb_ram_ws

Overview:
Parametrised APB4 slave RAM. Successor to the fixed 32x32 APB RAM, with configurable data width and depth, byte strobes, programmable wait states and a read-only upper region. After reset it runs a hardware scrub pass that zeroes the array. Sits on the peripheral APB segment as a generic scratch/config store.

Parameters:
DATA_W, 32, data bus width in bits; must be 8, 16, 32 or 64.
ADDR_W, 32, APB address width in bits.
DEPTH, 64, number of DATA_W words; must be a power of 2 and at least 2.
WAIT_STATES, 0, extra access-phase cycles inserted before o_pready; range 0..15.
RO_BASE, DEPTH, first word index of the read-only region. RO_BASE = DEPTH means no read-only region.

Ports:
i_pclk  in  1  clock; all logic on the rising edge.
i_presetn  in  1  reset, asynchronous assert, active-low.
i_psel  in  1  APB select.
i_penable  in  1  APB enable; high marks the access phase.
i_pwrite  in  1  1 = write, 0 = read.
i_paddr  in  ADDR_W  byte address.
i_pwdata  in  DATA_W  write data.
i_pstrb  in  DATA_W/8  write byte lanes; ignored on reads.
o_prdata  out  DATA_W  read data; valid only while o_pready=1.
o_pready  out  1  transfer complete; registered, one-cycle pulse.
o_pslverr  out  1  error response; valid only while o_pready=1.

Behaviour:
- Reset: asynchronous and active-low. While i_presetn=0: o_prdata=0, o_pready=0, o_pslverr=0, state=SCRUB, scrub pointer=0, wait counter=0.
- The memory array has no reset. Its contents are zeroed by the SCRUB state.
- LSB = log2(DATA_W/8). Word index = i_paddr[LSB+log2(DEPTH)-1 : LSB].
- States:
  - SCRUB: write 0 to the word at the scrub pointer, then increment the pointer. After DEPTH cycles go to IDLE. o_pready stays 0 throughout. A request arriving during SCRUB stays pending and is serviced from IDLE.
  - IDLE: when i_psel=1 and i_penable=1 are sampled, latch the wait counter = WAIT_STATES. If WAIT_STATES=0 go to RESP, else go to WAIT.
  - WAIT: decrement the counter each cycle; go to RESP at the edge where the counter reaches 0.
  - RESP: o_pready=1 for exactly one cycle, then return to IDLE. At the edge entering RESP, register o_prdata and o_pslverr and commit any write.
- Latency: let A = the first cycle with i_psel=1 and i_penable=1. o_pready is high in cycle A+1+WAIT_STATES.
- Error checks, evaluated at RESP entry. Any failure sets o_pslverr=1:
  - misaligned: i_paddr[LSB-1:0] != 0 (check applies only when DATA_W > 8).
  - out of range: i_paddr >> LSB >= DEPTH.
  - read-only write: i_pwrite=1 and word index >= RO_BASE.
- On error: no memory update, o_prdata=0.
- Write: for each lane b with i_pstrb[b]=1, update byte b from i_pwdata. Lanes with strobe 0 keep their value. i_pstrb=0 is a legal no-op with o_pslverr=0.
- Read: o_prdata = mem[index]. Lanes are not masked. Reads of the read-only region are legal.
- Outside RESP: o_prdata=0 and o_pslverr=0.
- Abort: if i_psel or i_penable drops during WAIT, return to IDLE with no write and no o_pready pulse.
- Back-to-back transfers: a new access phase sampled in the cycle after RESP is accepted normally.
- Mid-operation reset: pending write is discarded, outputs are cleared immediately, and SCRUB restarts from index 0.

Test Plan:
Defaults for all scenarios: DATA_W=32, DEPTH=64, WAIT_STATES=2, RO_BASE=48.
1. Release reset, read 0x000 and 0x0FC after the scrub -> o_prdata=0x00000000, o_pslverr=0. The first read's o_pready is not earlier than 64 cycles after release.
2. Write 0xDEADBEEF to 0x010 with strb=0xF, then write 0x000000AA with strb=0x1, then read 0x010 -> 0xDEADBEAA. Each o_pready appears exactly 3 cycles after the first access cycle.
3. Read 0x101 (misaligned) and read 0x100 (index 64, out of range) -> o_pslverr=1, o_prdata=0, memory unchanged.
4. Write 0x12345678 to 0x0C0 (index 48, read-only) -> o_pslverr=1. A following read of 0x0C0 returns 0x00000000 with o_pslverr=0.
5. Start a write of 0x55 to 0x020, then drop i_psel in the first WAIT cycle -> no o_pready pulse. A later read of 0x020 returns 0.
6. Pulse i_presetn low during the WAIT of a write to 0x030 -> outputs go to 0 in the same cycle, no write lands, and the scrub completes before the next o_pready.
